uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit asynchronous serial receiver with 16x oversampling.
//
// Frame: start bit (low), 8 data bits LSB first, optional even-parity bit,
// one stop bit (high). Build option: define UART_RX_PARITY_EN to expect the
// parity bit; a parity mismatch is reported the same way as a bad stop bit.
//
// Ports
//   sysclk        single clock, all state on the rising edge
//   reset         asynchronous, active-low
//   UART_RX       serial line, idle high, asynchronous to sysclk
//   rx_data       last accepted byte
//   rx_valid      rx_data holds an unconsumed byte
//   rx_ack        consumer takes rx_data this cycle
//   rx_busy       frame reception in progress
//   rx_frame_err  one-cycle pulse on a bad stop (or parity) bit
//   rx_overrun    sticky: a good byte was dropped while rx_valid was high
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | start bit, confirm it is still low at mid-bit
// DATA   | shifting in 8 data bits at successive mid-bit points
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then accept or reject the byte

module uart_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic             rx_s1, rx_s2;
  logic             rx_prev;
  logic [1:0]       sync_fill;
  logic             edge_pend;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             tick;
  logic             mid_bit;
  logic             fall;
  logic             start_ok;
  logic             shift_en;
  logic             stop_done;
  logic             frame_good;
`ifdef UART_RX_PARITY_EN
  logic             par_en;
  logic             par_err;
`endif

  assign tick    = (state_q != IDLE) && (div_cnt == DIV_LAST);
  assign mid_bit = tick && (tick_cnt == 4'd15);
  assign fall    = rx_prev & ~rx_s2;
  assign rx_busy = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign frame_good = stop_done & rx_s2 & ~par_err;
`else
  assign frame_good = stop_done & rx_s2;
`endif

  // Synchronizer flops come out of reset high, so rx_s2 only reflects the
  // real line two cycles after release. sync_fill tracks that, and rx_prev
  // stays low until a genuinely high line has been seen: a line that is
  // already low after reset (mid-frame abort) never looks like a new edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_s1     <= UART_RX;
      rx_s2     <= rx_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= rx_s2 & sync_fill[1];
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fall || edge_pend) state_d = START;
      end
      START: begin
        if (tick && (tick_cnt == 4'd7)) begin
          if (rx_s2) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            start_ok = 1'b1;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_d = PARITY;
`else
          if (bit_cnt == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_bit) begin
          par_en  = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_bit) begin
          stop_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Oversample divider runs only while a frame is in progress; holding it at
  // zero in IDLE means it starts clean on entry to START.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      if (state_q == IDLE || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + DIV_W'(1);

      // Re-zeroed at the start-bit mid-point so every later mid-bit lands on
      // the 16th tick, where tick_cnt naturally wraps.
      if (state_q == IDLE || start_ok) tick_cnt <= 4'd0;
      else if (tick)                   tick_cnt <= tick_cnt + 4'd1;

      if (state_q == IDLE) bit_cnt <= 3'd0;
      else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;

      if (shift_en) shift_q <= {rx_s2, shift_q[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)               par_err <= 1'b0;
    else if (state_q == IDLE) par_err <= 1'b0;
    else if (par_en)          par_err <= (rx_s2 != ^shift_q);
  end
`endif

  // A falling edge seen while finishing the stop bit would otherwise be lost
  // because IDLE only reacts to edges it observes itself.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                      edge_pend <= 1'b0;
    else if (state_q == IDLE)        edge_pend <= 1'b0;
    else if (state_q == STOP && fall) edge_pend <= 1'b1;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= stop_done & ~frame_good;
      if (frame_good && (!rx_valid || rx_ack)) begin
        rx_data    <= shift_q;
        rx_valid   <= 1'b1;
        rx_overrun <= 1'b0;
      end else begin
        if (rx_valid && rx_ack) begin
          rx_valid   <= 1'b0;
          rx_overrun <= 1'b0;
        end
        // Reaching here with a good frame means rx_valid=1 and no ack.
        if (frame_good) rx_overrun <= 1'b1;
      end
    end
  end

endmodule
